// File: rtl/store_streamer_if.sv
// Buffer-read, TX-FIFO-write and control handshake bundle for store_streamer.
// The master modport is the streamer; the slave modport is the surrounding controller/buffer/FIFO.
interface store_streamer_if #(
    parameter int unsigned BUFFER_WORD_SIZE = 16,
    parameter int unsigned FIFO_DATA_WIDTH  = 8,
    parameter int unsigned ADDRESS_SIZE     = 10
);
    logic                        start;
    logic [ADDRESS_SIZE-1:0]     base_addr;
    logic [ADDRESS_SIZE:0]       word_count;
    logic                        busy;
    logic                        done;
    logic                        buf_re;
    logic [ADDRESS_SIZE-1:0]     buf_addr;
    logic [BUFFER_WORD_SIZE-1:0] buf_rdata;
    logic                        fifo_we;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_wdata;
    logic                        fifo_full;

    modport master (
        input  start, base_addr, word_count, buf_rdata, fifo_full,
        output busy, done, buf_re, buf_addr, fifo_we, fifo_wdata
    );

    modport slave (
        output start, base_addr, word_count, buf_rdata, fifo_full,
        input  busy, done, buf_re, buf_addr, fifo_we, fifo_wdata
    );
endinterface

// File: rtl/store_streamer.sv
// Streams word_count buffer words to the TX FIFO as bytes (low first),
// preceded by a two-byte little-endian length header.
module store_streamer #(
    parameter int unsigned BUFFER_SIZE      = 1024,
    parameter int unsigned BUFFER_WORD_SIZE = 16,
    parameter int unsigned FIFO_DATA_WIDTH  = 8,
    parameter int unsigned ADDRESS_SIZE     = $clog2(BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    store_streamer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        READ,
        LATCH,
        SEND_LO,
        SEND_HI,
        DONE
    } state_t;

    localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE = ADDRESS_SIZE'(1);
    localparam logic [ADDRESS_SIZE:0]   REM_ONE  = (ADDRESS_SIZE + 1)'(1);

    state_t                      state_q, state_d;
    logic [ADDRESS_SIZE-1:0]     addr_q, addr_d;
    logic [ADDRESS_SIZE:0]       remaining_q, remaining_d;
    logic [BUFFER_WORD_SIZE-1:0] word_q, word_d;
    logic [BUFFER_WORD_SIZE-1:0] header;

    // remaining is untouched until the first SEND_HI, so it still holds the captured count
    assign header = BUFFER_WORD_SIZE'(remaining_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        word_d         = word_q;
        bus.busy       = (state_q != IDLE);
        bus.done       = 1'b0;
        bus.buf_re     = 1'b0;
        bus.buf_addr   = addr_q;
        bus.fifo_we    = 1'b0;
        bus.fifo_wdata = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.word_count;
                    state_d     = HDR_LO;
                end
            end
            HDR_LO: begin
                bus.fifo_we    = ~bus.fifo_full;
                bus.fifo_wdata = header[FIFO_DATA_WIDTH-1:0];
                if (!bus.fifo_full) state_d = HDR_HI;
            end
            HDR_HI: begin
                bus.fifo_we    = ~bus.fifo_full;
                bus.fifo_wdata = header[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
                if (!bus.fifo_full) state_d = (remaining_q == '0) ? DONE : READ;
            end
            READ: begin
                bus.buf_re = 1'b1;
                state_d    = LATCH;
            end
            LATCH: begin
                word_d  = bus.buf_rdata;
                state_d = SEND_LO;
            end
            SEND_LO: begin
                bus.fifo_we    = ~bus.fifo_full;
                bus.fifo_wdata = word_q[FIFO_DATA_WIDTH-1:0];
                if (!bus.fifo_full) state_d = SEND_HI;
            end
            SEND_HI: begin
                bus.fifo_we    = ~bus.fifo_full;
                bus.fifo_wdata = word_q[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
                if (!bus.fifo_full) begin
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    state_d     = (remaining_q == REM_ONE) ? DONE : READ;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_streamer.sv
// Self-checking bench for store_streamer: directed test-plan scenarios plus
// randomized streams with random backpressure against a behavioural model.
module tb_store_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    store_streamer_if #(.BUFFER_WORD_SIZE(16), .FIFO_DATA_WIDTH(8), .ADDRESS_SIZE(10)) bus ();

    store_streamer #(
        .BUFFER_SIZE(1024),
        .BUFFER_WORD_SIZE(16),
        .FIFO_DATA_WIDTH(8),
        .ADDRESS_SIZE(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    bit          full_pat [0:8191];

    // Synchronous-read buffer: data appears the cycle after buf_re
    always @(posedge clk) begin
        if (bus.buf_re) bus.buf_rdata = mem[bus.buf_addr];
    end

    int errors = 0;
    int checks = 0;

    logic [7:0] got_bytes [$];
    int         got_we_cyc [$];
    logic [9:0] got_addr [$];
    bit         busy_hist [$];
    int         done_cyc, done_cnt, busy_cnt;
    bit         idle_after, timed_out;

    logic [7:0] exp_bytes [$];
    logic [9:0] exp_addr [$];

    task automatic clear_pat();
        for (int i = 0; i < 8192; i++) full_pat[i] = 1'b0;
    endtask

    // Expected stream derived directly from the byte-order rules
    task automatic build_expected(input logic [9:0] base, input logic [10:0] count);
        logic [15:0] w;
        logic [9:0]  a;
        logic [15:0] cnt16;
        exp_bytes.delete();
        exp_addr.delete();
        cnt16 = {5'b0, count};
        exp_bytes.push_back(cnt16[7:0]);
        exp_bytes.push_back(cnt16[15:8]);
        for (int k = 0; k < int'(count); k++) begin
            a = 10'((int'(base) + k) % 1024);
            w = mem[a];
            exp_addr.push_back(a);
            exp_bytes.push_back(w[7:0]);
            exp_bytes.push_back(w[15:8]);
        end
    endtask

    // Cycle of done: byte phases stall on full, fixed phases take one cycle
    function automatic int model_done(input int n);
        int c = 1;
        for (int p = 0; p < 2 + 4 * n; p++) begin
            bit is_byte = (p < 2) || (((p - 2) % 4) >= 2);
            if (is_byte) while (full_pat[c]) c++;
            c++;
        end
        return c;
    endfunction

    task automatic run_stream(input logic [9:0] base, input logic [10:0] count,
                              input int restart_cyc, input int rst_cyc, input int max_cyc);
        got_bytes.delete();
        got_we_cyc.delete();
        got_addr.delete();
        busy_hist.delete();
        done_cyc   = -1;
        done_cnt   = 0;
        busy_cnt   = 0;
        idle_after = 1'b0;
        timed_out  = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= max_cyc; c++) begin
            bus.fifo_full = full_pat[c];
            bus.start     = (c == 0) || (c == restart_cyc) || (c == rst_cyc);
            rst           = (c == rst_cyc) ? 1'b0 : 1'b1;
            if (c == 0) begin
                bus.base_addr  = base;
                bus.word_count = count;
            end else if (c == restart_cyc) begin
                bus.base_addr  = ~base;
                bus.word_count = 11'd5;
            end
            #1;
            if (bus.fifo_we) begin
                got_bytes.push_back(bus.fifo_wdata);
                got_we_cyc.push_back(c);
            end
            if (bus.buf_re) got_addr.push_back(bus.buf_addr);
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.busy) busy_cnt++;
            busy_hist.push_back(bus.busy);
            if (rst_cyc >= 0 && c == max_cyc) timed_out = 1'b0;
            if (done_cnt > 0 && c == done_cyc + 1) begin
                idle_after = !bus.busy;
                timed_out  = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.fifo_full = 1'b0;
        rst           = 1'b1;
        checks++;
        if (timed_out !== 1'b0) begin
            errors++;
            $display("FAIL stream_timeout: got no completion within %0d cycles, required done", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.start     = 1'b1;
        bus.base_addr = 10'h155;
        bus.word_count = 11'd3;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
        checks++; if (bus.buf_re !== 1'b0)     begin errors++; $display("FAIL reset_buf_re: got %b required 0", bus.buf_re); end
        checks++; if (bus.fifo_we !== 1'b0)    begin errors++; $display("FAIL reset_fifo_we: got %b required 0", bus.fifo_we); end
        checks++; if (bus.buf_addr !== 10'h0)  begin errors++; $display("FAIL reset_buf_addr: got %h required 000", bus.buf_addr); end
        checks++; if (bus.fifo_wdata !== 8'h0) begin errors++; $display("FAIL reset_fifo_wdata: got %h required 00", bus.fifo_wdata); end
        bus.start = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy got %b required 0", bus.busy); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [6] = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'h34, 8'h12};
        int         exp_c [6] = '{1, 2, 5, 6, 9, 10};
        clear_pat();
        mem[10'h010] = 16'hBEEF;
        mem[10'h011] = 16'h1234;
        run_stream(10'h010, 11'd2, -1, -1, 40);
        checks++; if (got_bytes.size() !== 6) begin errors++; $display("FAIL basic_nbytes: got %0d required 6", got_bytes.size()); end
        for (int i = 0; i < 6 && i < got_bytes.size(); i++) begin
            checks++; if (got_bytes[i] !== exp[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %h required %h", i, got_bytes[i], exp[i]); end
            checks++; if (got_we_cyc[i] !== exp_c[i]) begin errors++; $display("FAIL basic_write_cycle[%0d]: got %0d required %0d", i, got_we_cyc[i], exp_c[i]); end
        end
        checks++; if (busy_hist[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_cycle0: got %b required 0", busy_hist[0]); end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL basic_done_cycle: got %0d required 11", done_cyc); end
        checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
        checks++; if (busy_cnt !== 11) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 11", busy_cnt); end
        checks++; if (idle_after !== 1'b1) begin errors++; $display("FAIL basic_idle_after: got %b required 1", idle_after); end
        checks++; if (got_addr.size() !== 2) begin errors++; $display("FAIL basic_nreads: got %0d required 2", got_addr.size()); end
    endtask

    task automatic test_zero_count();
        clear_pat();
        run_stream(10'h055, 11'd0, -1, -1, 20);
        checks++; if (got_bytes.size() !== 2) begin errors++; $display("FAIL zero_nbytes: got %0d required 2", got_bytes.size()); end
        for (int i = 0; i < 2 && i < got_bytes.size(); i++) begin
            checks++; if (got_bytes[i] !== 8'h00) begin errors++; $display("FAIL zero_byte[%0d]: got %h required 00", i, got_bytes[i]); end
        end
        checks++; if (done_cyc !== 3) begin errors++; $display("FAIL zero_done_cycle: got %0d required 3", done_cyc); end
        checks++; if (got_addr.size() !== 0) begin errors++; $display("FAIL zero_buf_re: got %0d reads required 0", got_addr.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [6] = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'h34, 8'h12};
        clear_pat();
        full_pat[2] = 1'b1; full_pat[3] = 1'b1;
        full_pat[7] = 1'b1; full_pat[8] = 1'b1; full_pat[9] = 1'b1;
        mem[10'h010] = 16'hBEEF;
        mem[10'h011] = 16'h1234;
        run_stream(10'h010, 11'd2, -1, -1, 40);
        checks++; if (got_bytes.size() !== 6) begin errors++; $display("FAIL bp_nbytes: got %0d required 6", got_bytes.size()); end
        for (int i = 0; i < 6 && i < got_bytes.size(); i++) begin
            checks++; if (got_bytes[i] !== exp[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h required %h", i, got_bytes[i], exp[i]); end
        end
        checks++; if (done_cyc !== 16) begin errors++; $display("FAIL bp_done_cycle: got %0d required 16", done_cyc); end
        checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL bp_busy_cycles: got %0d required 16", busy_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [6] = '{8'h02, 8'h00, 8'hAA, 8'hAA, 8'h55, 8'h55};
        clear_pat();
        mem[10'h3FF] = 16'hAAAA;
        mem[10'h000] = 16'h5555;
        run_stream(10'h3FF, 11'd2, -1, -1, 40);
        checks++; if (got_addr.size() !== 2) begin errors++; $display("FAIL wrap_nreads: got %0d required 2", got_addr.size()); end
        if (got_addr.size() == 2) begin
            checks++; if (got_addr[0] !== 10'h3FF) begin errors++; $display("FAIL wrap_addr0: got %h required 3ff", got_addr[0]); end
            checks++; if (got_addr[1] !== 10'h000) begin errors++; $display("FAIL wrap_addr1: got %h required 000", got_addr[1]); end
        end
        checks++; if (got_bytes.size() !== 6) begin errors++; $display("FAIL wrap_nbytes: got %0d required 6", got_bytes.size()); end
        for (int i = 0; i < 6 && i < got_bytes.size(); i++) begin
            checks++; if (got_bytes[i] !== exp[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h required %h", i, got_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_restart_and_reset();
        clear_pat();
        mem[10'h010] = 16'hBEEF;
        mem[10'h011] = 16'h1234;
        build_expected(10'h010, 11'd2);
        // start pulsed during SEND_HI of word 0 (cycle 6) must be ignored
        run_stream(10'h010, 11'd2, 6, -1, 40);
        checks++; if (got_bytes.size() !== exp_bytes.size()) begin errors++; $display("FAIL restart_nbytes: got %0d required %0d", got_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
            checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL restart_byte[%0d]: got %h required %h", i, got_bytes[i], exp_bytes[i]); end
        end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL restart_done_cycle: got %0d required 11", done_cyc); end
        checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL restart_done_count: got %0d required 1", done_cnt); end

        // reset (with coincident start) during LATCH of word 1 (cycle 8)
        mem[10'h020] = 16'hC3A5;
        mem[10'h021] = 16'h7E81;
        build_expected(10'h020, 11'd2);
        run_stream(10'h020, 11'd2, -1, 8, 24);
        checks++; if (got_bytes.size() !== 4) begin errors++; $display("FAIL rst_nbytes: got %0d required 4", got_bytes.size()); end
        for (int i = 0; i < 4 && i < got_bytes.size(); i++) begin
            checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL rst_byte[%0d]: got %h required %h", i, got_bytes[i], exp_bytes[i]); end
        end
        checks++; if (busy_hist[9] !== 1'b0) begin errors++; $display("FAIL rst_busy_next: got %b required 0", busy_hist[9]); end
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL rst_busy_cycles: got %0d required 8", busy_cnt); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_done_count: got %0d required 0", done_cnt); end
    endtask

    task automatic test_full_buffer();
        int bad_b = 0;
        int bad_a = 0;
        clear_pat();
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        build_expected(10'h200, 11'd1024);
        run_stream(10'h200, 11'd1024, -1, -1, 4200);
        checks++; if (got_bytes.size() !== 2050) begin errors++; $display("FAIL full_nbytes: got %0d required 2050", got_bytes.size()); end
        if (got_bytes.size() >= 2) begin
            checks++; if (got_bytes[0] !== 8'h00) begin errors++; $display("FAIL full_hdr_lo: got %h required 00", got_bytes[0]); end
            checks++; if (got_bytes[1] !== 8'h04) begin errors++; $display("FAIL full_hdr_hi: got %h required 04", got_bytes[1]); end
        end
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
            checks++;
            if (got_bytes[i] !== exp_bytes[i]) begin
                errors++;
                if (bad_b < 8) $display("FAIL full_byte[%0d]: got %h required %h", i, got_bytes[i], exp_bytes[i]);
                bad_b++;
            end
        end
        checks++; if (got_addr.size() !== 1024) begin errors++; $display("FAIL full_nreads: got %0d required 1024", got_addr.size()); end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            checks++;
            if (got_addr[k] !== exp_addr[k]) begin
                errors++;
                if (bad_a < 8) $display("FAIL full_addr[%0d]: got %h required %h", k, got_addr[k], exp_addr[k]);
                bad_a++;
            end
        end
        checks++; if (done_cyc !== 4099) begin errors++; $display("FAIL full_done_cycle: got %0d required 4099", done_cyc); end
    endtask

    task automatic test_random();
        logic [9:0]  base;
        logic [10:0] count;
        int          exp_done;
        for (int it = 0; it < 10; it++) begin
            base  = 10'($urandom_range(0, 1023));
            count = 11'($urandom_range(0, 24));
            for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
            clear_pat();
            for (int c = 1; c < 400; c++) full_pat[c] = ($urandom_range(0, 2) == 0);
            build_expected(base, count);
            exp_done = model_done(int'(count));
            run_stream(base, count, -1, -1, exp_done + 20);
            checks++; if (got_bytes.size() !== exp_bytes.size()) begin errors++; $display("FAIL rand%0d_nbytes: got %0d required %0d", it, got_bytes.size(), exp_bytes.size()); end
            for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
                checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL rand%0d_byte[%0d]: got %h required %h", it, i, got_bytes[i], exp_bytes[i]); end
            end
            checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rand%0d_nreads: got %0d required %0d", it, got_addr.size(), exp_addr.size()); end
            for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
                checks++; if (got_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL rand%0d_addr[%0d]: got %h required %h", it, k, got_addr[k], exp_addr[k]); end
            end
            checks++; if (done_cyc !== exp_done) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d required %0d", it, done_cyc, exp_done); end
            checks++; if (busy_cnt !== exp_done) begin errors++; $display("FAIL rand%0d_busy_cycles: got %0d required %0d", it, busy_cnt, exp_done); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d required 1", it, done_cnt); end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.buf_rdata  = '0;
        bus.fifo_full  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        clear_pat();
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_wrap();
        test_restart_and_reset();
        test_full_buffer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/store_streamer.md
# store_streamer

Device-to-host result path. On `start`, reads `word_count` 16-bit words from the unified buffer beginning at `base_addr` and pushes them into the transmit FIFO as bytes, low byte first. The stream is preceded by a two-byte length header. It is the mirror of the controller's instruction/address fetch, which assembles 16-bit values from RX FIFO bytes low-half-first. It sits between the unified buffer read port and `fifo_tx`, and is driven by the controller's STORE_STREAM state.

## Interface
Parameters:
- `BUFFER_SIZE`, 1024: buffer depth in words.
- `BUFFER_WORD_SIZE`, 16: buffer word width. Fixed at 2×`FIFO_DATA_WIDTH`.
- `FIFO_DATA_WIDTH`, 8: TX FIFO byte width.
- `ADDRESS_SIZE`, `$clog2(BUFFER_SIZE)`: buffer address width.

Ports:
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle request. Sampled only in IDLE.
- `base_addr`, in, ADDRESS_SIZE: first buffer word. Captured on accepted `start`.
- `word_count`, in, ADDRESS_SIZE+1: number of words to send, 0..BUFFER_SIZE. Captured on accepted `start`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `buf_re`, out, 1: buffer read enable.
- `buf_addr`, out, ADDRESS_SIZE: buffer read address.
- `buf_rdata`, in, BUFFER_WORD_SIZE: buffer read data. Valid the cycle after `buf_re`.
- `fifo_we`, out, 1: TX FIFO write strobe.
- `fifo_wdata`, out, FIFO_DATA_WIDTH: byte to write.
- `fifo_full`, in, 1: TX FIFO full flag.

## Operation
- States: IDLE → HDR_LO → HDR_HI → {READ → LATCH → SEND_LO → SEND_HI}×N → DONE → IDLE.
- IDLE: if `start`=1, capture `base_addr` into the address register and `word_count` into the remaining counter, then go to HDR_LO.
- HDR_LO / HDR_HI: emit the captured count zero-extended to 16 bits, low byte then high byte.
- After HDR_HI: if remaining = 0, go to DONE; otherwise go to READ.
- READ: `buf_re`=1 and `buf_addr`=address register, for exactly one cycle.
- LATCH: register `buf_rdata` into the word register.
- SEND_LO: emits `word[7:0]`.
- SEND_HI: emits `word[15:8]`. On the write, increment the address and decrement remaining. If the new remaining = 0, go to DONE; otherwise go to READ.
- Byte-emitting states (HDR_LO, HDR_HI, SEND_LO, SEND_HI):
  - `fifo_we` = ~`fifo_full`, combinational.
  - `fifo_wdata` holds the byte.
  - The state advances only on a cycle where `fifo_we`=1.
  - While `fifo_full`=1 the state holds with `fifo_we`=0. No byte is lost or duplicated.
- Address arithmetic is modulo 2^ADDRESS_SIZE, so address BUFFER_SIZE-1 wraps to 0.
- `word_count` = BUFFER_SIZE is legal: the whole buffer is sent once, starting at `base_addr`.
- A `start` asserted while `busy` is ignored and does not retrigger.
- Outside READ: `buf_re`=0. `buf_addr` holds the address register (don't-care).
- Outside byte states: `fifo_we`=0 and `fifo_wdata`=0.

## Timing
- Reset (`rst`=0 at a clock edge): state = IDLE; address, remaining and word registers = 0.
- Reset values of outputs: `busy`, `done`, `buf_re`, `fifo_we` = 0; `buf_addr`, `fifo_wdata` = 0.
- Reset mid-stream:
  - The next cycle is IDLE with all outputs at reset values.
  - A partially sent word is abandoned and no further FIFO writes occur.
  - A `start` coincident with reset is ignored.
- With `fifo_full` held 0, take `start` sampled at cycle 0:
  - Header bytes are written in cycles 1–2.
  - Word k has `buf_re` in cycle 3+4k, its low byte written in 5+4k, its high byte in 6+4k.
  - `done`=1 in cycle 3+4N. IDLE resumes in cycle 4+4N.
- Every cycle `fifo_full` is high in a byte state adds exactly one cycle of latency.
- `fifo_full` during READ or LATCH has no effect.
- `start` can be accepted again in the cycle after DONE.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- Basic stream: buffer[0x010]=0xBEEF, buffer[0x011]=0x1234; start with base=0x010, count=2, `fifo_full`=0.
  - FIFO receives 02,00,EF,BE,34,12.
  - `done` in cycle 11, `busy` high in cycles 1–11.
- Zero count: start with count=0.
  - FIFO receives 00,00.
  - `done` in cycle 3, `buf_re` never asserted.
- Backpressure: same as the basic stream, with `fifo_full`=1 for 3 cycles during the first SEND_LO, and again for 2 cycles during HDR_HI.
  - Same 6 bytes, each written exactly once.
  - `done` in cycle 16.
- Wrap-around: base=0x3FF, count=2, buffer[0x3FF]=0xAAAA, buffer[0x000]=0x5555.
  - `buf_addr` sequence 0x3FF then 0x000.
  - FIFO receives 02,00,AA,AA,55,55.
- Mid-stream reset and ignored restart:
  - Pulse `start` during SEND_HI of word 0. No effect; the stream completes normally.
  - Start a new stream and assert `rst`=0 during LATCH of word 1. The next cycle has `busy`=0, and no further `fifo_we` until a new `start`.
- Full buffer: count=1024, base=0x200.
  - 2050 bytes written, with header 00,04.
  - Addresses 0x200..0x3FF then 0x000..0x1FF.
  - `done` in cycle 4099.
